// File: rtl/div_unit_pkg.sv
// Shared control definitions for the divide unit and the decoder that issues to it.
// Holds the divsel encodings, the divider state enum and the default datapath width.
// Pure declarations; no timing or flow-control behaviour lives here.
package div_unit_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int CNT_W        = 6;

    localparam logic [2:0] DIVSEL_DIV  = 3'b001;
    localparam logic [2:0] DIVSEL_DIVU = 3'b010;
    localparam logic [2:0] DIVSEL_REM  = 3'b011;
    localparam logic [2:0] DIVSEL_REMU = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } div_state_e;

    function automatic logic divsel_valid(input logic [2:0] sel);
        return (sel == DIVSEL_DIV) || (sel == DIVSEL_DIVU) ||
               (sel == DIVSEL_REM) || (sel == DIVSEL_REMU);
    endfunction

    function automatic logic divsel_signed(input logic [2:0] sel);
        return (sel == DIVSEL_DIV) || (sel == DIVSEL_REM);
    endfunction

    function automatic logic divsel_is_rem(input logic [2:0] sel);
        return (sel == DIVSEL_REM) || (sel == DIVSEL_REMU);
    endfunction

endpackage

// File: rtl/div_unit_step.sv
// One restoring shift-subtract iteration of an unsigned divide.
// Purely combinational, zero latency.
// No flow control; the caller decides when the result is registered.
module div_step
    import div_unit_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN:0]   rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN:0]   rem_o,
    output logic [XLEN-1:0] quo_o
);

    logic [XLEN+1:0] shifted;
    logic [XLEN+1:0] diff;
    logic            fits;

    // Shift the next dividend bit into the remainder; keep the trial
    // difference only when it does not borrow. The extra top bit makes the
    // borrow visible even though the partial remainder is XLEN+1 wide.
    always_comb begin
        shifted = {rem_i, quo_i[XLEN-1]};
        diff    = shifted - {2'b00, divisor_i};
        fits    = ~diff[XLEN+1];
        rem_o   = fits ? diff[XLEN:0] : shifted[XLEN:0];
        quo_o   = {quo_i[XLEN-2:0], fits};
    end

endmodule

// File: rtl/div_unit.sv
// Iterative signed/unsigned divide and remainder unit, one quotient bit per cycle.
// Latency: result 32 edges after the start edge, or on the start edge for divide-by-zero / overflow.
// Backpressure: busy is held while occupied; starts offered while busy are ignored, flush aborts.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int TAGW = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            div_inst,
    input  logic [2:0]      divsel,
    input  logic            flush,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [TAGW-1:0] rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [TAGW-1:0] rd_out
);

    localparam logic [XLEN-1:0]  ONE_VAL  = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0]  MIN_VAL  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] v);
        return (~v) + ONE_VAL;
    endfunction

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [TAGW-1:0]  tag_q, tag_d;
    logic [TAGW-1:0]  rd_out_q, rd_out_d;
    logic             neg1_q, neg1_d;
    logic             neg2_q, neg2_d;
    logic [XLEN-1:0]  divisor_q, divisor_d;
    logic [XLEN-1:0]  quo_q, quo_d;
    logic [XLEN:0]    rem_q, rem_d;
    logic [XLEN-1:0]  result_q, result_d;

    logic [XLEN:0]    step_rem;
    logic [XLEN-1:0]  step_quo;

    logic             start;
    logic             sgn_op;
    logic             by_zero;
    logic             ovf;
    logic [XLEN-1:0]  opa;
    logic [XLEN-1:0]  opb;
    logic [XLEN-1:0]  special_res;
    logic [XLEN-1:0]  final_res;

    div_step #(
        .XLEN (XLEN)
    ) u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (divisor_q),
        .rem_o     (step_rem),
        .quo_o     (step_quo)
    );

    // Issue-side decode: accept, special-case detection, operand magnitudes.
    always_comb begin
        sgn_op  = divsel_signed(divsel);
        start   = div_inst && divsel_valid(divsel) && !flush && (state_q == ST_IDLE);
        by_zero = (rs2 == '0);
        ovf     = sgn_op && (rs1 == MIN_VAL) && (rs2 == '1);
        opa     = (sgn_op && rs1[XLEN-1]) ? negate(rs1) : rs1;
        opb     = (sgn_op && rs2[XLEN-1]) ? negate(rs2) : rs2;
        if (by_zero) begin
            special_res = divsel_is_rem(divsel) ? rs1 : '1;
        end else begin
            special_res = divsel_is_rem(divsel) ? '0 : MIN_VAL;
        end
    end

    // Sign correction of the last iteration's output; unsigned ops carry clear sign flags.
    always_comb begin
        if (divsel_is_rem(op_q)) begin
            final_res = neg1_q ? negate(step_rem[XLEN-1:0]) : step_rem[XLEN-1:0];
        end else begin
            final_res = (neg1_q ^ neg2_q) ? negate(step_quo) : step_quo;
        end
    end

    // Next-state and datapath update; flush overrides every transition.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        tag_d     = tag_q;
        rd_out_d  = rd_out_q;
        neg1_d    = neg1_q;
        neg2_d    = neg2_q;
        divisor_d = divisor_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        result_d  = result_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d      = divsel;
                    tag_d     = rd_in;
                    neg1_d    = sgn_op && rs1[XLEN-1];
                    neg2_d    = sgn_op && rs2[XLEN-1];
                    divisor_d = opb;
                    quo_d     = opa;
                    rem_d     = '0;
                    cnt_d     = '0;
                    if (by_zero || ovf) begin
                        state_d  = ST_DONE;
                        result_d = special_res;
                        rd_out_d = rd_in;
                    end else begin
                        state_d  = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d  = ST_DONE;
                    cnt_d    = '0;
                    result_d = final_res;
                    rd_out_d = tag_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (flush) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            result_d = result_q;
            rd_out_d = rd_out_q;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            op_q      <= '0;
            tag_q     <= '0;
            rd_out_q  <= '0;
            neg1_q    <= 1'b0;
            neg2_q    <= 1'b0;
            divisor_q <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            result_q  <= '0;
        end else begin
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            tag_q     <= tag_d;
            rd_out_q  <= rd_out_d;
            neg1_q    <= neg1_d;
            neg2_q    <= neg2_d;
            divisor_q <= divisor_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            result_q  <= result_d;
        end
    end

    assign busy   = (state_q != ST_IDLE);
    assign done   = (state_q == ST_DONE);
    assign result = result_q;
    assign rd_out = rd_out_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: expected result/tag/latency queued at issue, compared at done.
// Latency is measured in edges after the start edge (0 for special cases, 32 otherwise).
// Flush, invalid-issue, held-issue and mid-operation reset scenarios are exercised.
module tb_div_unit;

    logic        clk;
    logic        rst_n;
    logic        div_inst;
    logic [2:0]  divsel;
    logic        flush;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  rd_in;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] exp_res_q[$];
    logic [4:0]  exp_tag_q[$];
    int          exp_lat_q[$];

    div_unit #(
        .XLEN (32),
        .TAGW (5)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .div_inst (div_inst),
        .divsel   (divsel),
        .flush    (flush),
        .rs1      (rs1),
        .rs2      (rs2),
        .rd_in    (rd_in),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .rd_out   (rd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic sgn;
        sgn = (op == 3'b001) || (op == 3'b011);
        return (b == 32'd0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        r = 32'd0;
        case (op)
            3'b001: begin
                if (b == 32'd0) r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
                else r = $signed(a) / $signed(b);
            end
            3'b010: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'b011: begin
                if (b == 32'd0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
                else r = $signed(a) % $signed(b);
            end
            3'b100: r = (b == 32'd0) ? a : a % b;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one issue cycle and queues the expectation.
    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
        div_inst = 1'b1;
        divsel   = op;
        rs1      = a;
        rs2      = b;
        rd_in    = tag;
        exp_res_q.push_back(model(op, a, b));
        exp_tag_q.push_back(tag);
        exp_lat_q.push_back(is_special(op, a, b) ? 0 : 32);
        step();
        div_inst = 1'b0;
        rs1      = $urandom;
        rs2      = $urandom;
        rd_in    = 5'($urandom);
    endtask

    task automatic sb_drop();
        void'(exp_res_q.pop_front());
        void'(exp_tag_q.pop_front());
        void'(exp_lat_q.pop_front());
    endtask

    // Observes the DUT from the cycle after the start edge until done (bounded).
    task automatic wait_done(output int lat, output logic [31:0] res, output logic [4:0] tag, output int bcyc);
        lat  = -1;
        res  = 32'd0;
        tag  = 5'd0;
        bcyc = 0;
        for (int e = 0; e <= 40; e++) begin
            if (e > 0) step();
            if (busy === 1'b1) bcyc++;
            if (done === 1'b1) begin
                lat = e;
                res = result;
                tag = rd_out;
                break;
            end
        end
    endtask

    task automatic run_and_compare(input string name, input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [4:0] t);
        int          lat, bcyc, elat;
        logic [31:0] res, eres;
        logic [4:0]  tag, etag;
        start_op(op, a, b, t);
        wait_done(lat, res, tag, bcyc);
        eres = exp_res_q.pop_front();
        etag = exp_tag_q.pop_front();
        elat = exp_lat_q.pop_front();
        n_cmp++;
        if (lat !== elat) begin
            n_bad++;
            $display("FAIL %s latency: got %0d want %0d", name, lat, elat);
        end
        n_cmp++;
        if (res !== eres) begin
            n_bad++;
            $display("FAIL %s result: got %h want %h (op %b a %h b %h)", name, res, eres, op, a, b);
        end
        n_cmp++;
        if (tag !== etag) begin
            n_bad++;
            $display("FAIL %s rd_out: got %0d want %0d", name, tag, etag);
        end
        n_cmp++;
        if (bcyc !== elat + 1) begin
            n_bad++;
            $display("FAIL %s busy_cycles: got %0d want %0d", name, bcyc, elat + 1);
        end
        step();
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL %s after_done: busy %b done %b want 0 0", name, busy, done);
        end
    endtask

    task automatic test_reset();
        #3;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0 || rd_out !== 5'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: busy %b done %b result %h rd_out %0d want all 0", busy, done, result, rd_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release: busy %b done %b want 0 0", busy, done);
        end
    endtask

    task automatic test_unsigned();
        run_and_compare("divu_100_7", 3'b010, 32'd100, 32'd7, 5'd3);
        run_and_compare("remu_100_7", 3'b100, 32'd100, 32'd7, 5'd5);
        run_and_compare("divu_max_1", 3'b010, 32'hFFFF_FFFF, 32'd1, 5'd6);
        run_and_compare("remu_max_16", 3'b100, 32'hFFFF_FFFF, 32'h10, 5'd7);
        run_and_compare("divu_small_big", 3'b010, 32'd3, 32'hFFFF_FFF0, 5'd8);
    endtask

    task automatic test_signed();
        logic [2:0] ops [4] = '{3'b001, 3'b010, 3'b011, 3'b100};
        run_and_compare("div_m7_2", 3'b001, 32'hFFFF_FFF9, 32'd2, 5'd10);
        run_and_compare("rem_m7_2", 3'b011, 32'hFFFF_FFF9, 32'd2, 5'd11);
        run_and_compare("div_7_m2", 3'b001, 32'd7, 32'hFFFF_FFFE, 5'd12);
        run_and_compare("rem_m7_m2", 3'b011, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 5'd13);
        run_and_compare("div_min_2", 3'b001, 32'h8000_0000, 32'd2, 5'd14);
        for (int i = 0; i < 8; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 50)) : $urandom;
            if ($urandom_range(0, 3) == 0) b = -b;
            if (b == 32'd0) b = 32'd3;
            run_and_compare("random_op", ops[$urandom_range(0, 3)], a, b, 5'($urandom));
        end
    endtask

    task automatic test_special();
        run_and_compare("div_by_zero", 3'b001, 32'd5, 32'd0, 5'd20);
        run_and_compare("rem_by_zero", 3'b011, 32'd5, 32'd0, 5'd21);
        run_and_compare("divu_zero_zero", 3'b010, 32'd0, 32'd0, 5'd22);
        run_and_compare("remu_by_zero", 3'b100, 32'd9, 32'd0, 5'd23);
        run_and_compare("div_overflow", 3'b001, 32'h8000_0000, 32'hFFFF_FFFF, 5'd24);
        run_and_compare("rem_overflow", 3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 5'd25);
        // Flush arriving while done is already showing.
        start_op(3'b001, 32'd77, 32'd0, 5'd26);
        sb_drop();
        flush = 1'b1;
        #1;
        n_cmp++;
        if (done !== 1'b1 || result !== 32'hFFFF_FFFF || rd_out !== 5'd26) begin
            n_bad++;
            $display("FAIL flush_in_done: done %b result %h rd_out %0d want 1 ffffffff 26", done, result, rd_out);
        end
        step();
        flush = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'hFFFF_FFFF) begin
            n_bad++;
            $display("FAIL flush_in_done_after: busy %b done %b result %h want 0 0 ffffffff", busy, done, result);
        end
    endtask

    task automatic test_flush();
        int dones;
        // Issues that must be ignored: invalid codes and issue alongside flush.
        div_inst = 1'b1; rs1 = 32'd50; rs2 = 32'd5; rd_in = 5'd1;
        divsel = 3'b000; step();
        divsel = 3'b111; step();
        divsel = 3'b010; flush = 1'b1; step();
        div_inst = 1'b0; flush = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL ignored_issue: busy %b done %b want 0 0", busy, done);
        end
        // Abort mid-calculation: start is edge 1, flush sampled at edge 11.
        start_op(3'b010, 32'd1000, 32'd7, 5'd9);
        sb_drop();
        for (int i = 0; i < 9; i++) step();
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL flush_pre_busy: got %b want 1", busy);
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_abort: busy %b done %b want 0 0", busy, done);
        end
        run_and_compare("divu_9_3_after_flush", 3'b010, 32'd9, 32'd3, 5'd17);
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done === 1'b1) dones++;
        end
        n_cmp++;
        if (dones !== 0) begin
            n_bad++;
            $display("FAIL flush_stray_done: got %0d want 0", dones);
        end
    endtask

    task automatic test_held_issue();
        int          dones;
        logic [31:0] res;
        logic [4:0]  tag;
        dones = 0; res = 32'd0; tag = 5'd0;
        div_inst = 1'b1; divsel = 3'b010; rs1 = 32'd1000; rs2 = 32'd10; rd_in = 5'd4;
        step();
        rs1 = 32'd55; rs2 = 32'd5; rd_in = 5'd8;
        for (int i = 0; i < 45; i++) begin
            if (done === 1'b1) begin
                dones++;
                res = result;
                tag = rd_out;
                div_inst = 1'b0;
            end
            step();
        end
        div_inst = 1'b0;
        n_cmp++;
        if (dones !== 1) begin
            n_bad++;
            $display("FAIL held_issue_dones: got %0d want 1", dones);
        end
        n_cmp++;
        if (res !== 32'd100 || tag !== 5'd4) begin
            n_bad++;
            $display("FAIL held_issue_result: got %h tag %0d want 00000064 tag 4", res, tag);
        end
    endtask

    task automatic test_reset_mid();
        int dones, busys;
        start_op(3'b010, 32'd123456, 32'd11, 5'd30);
        sb_drop();
        for (int i = 0; i < 18; i++) step();
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0 || rd_out !== 5'd0) begin
            n_bad++;
            $display("FAIL reset_mid_outputs: busy %b done %b result %h rd_out %0d want all 0", busy, done, result, rd_out);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0; busys = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done === 1'b1) dones++;
            if (busy === 1'b1) busys++;
        end
        n_cmp++;
        if (dones !== 0 || busys !== 0) begin
            n_bad++;
            $display("FAIL reset_mid_after: dones %0d busy_cycles %0d want 0 0", dones, busys);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        div_inst = 1'b0;
        divsel   = 3'b000;
        flush    = 1'b0;
        rs1      = 32'd0;
        rs2      = 32'd0;
        rd_in    = 5'd0;
        test_reset();
        test_unsigned();
        test_signed();
        test_special();
        test_flush();
        test_held_issue();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter TAGW, default 5, destination-register tag width.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port div_inst  input  1  divide-class instruction present in the decode-to-execute stage.
REQ-006 SHALL have port divsel  input  3  operation select: 001 div, 010 divu, 011 rem, 100 remu; all other codes invalid.
REQ-007 SHALL have port flush  input  1  pipeline flush; aborts any operation in progress.
REQ-008 SHALL have port rs1  input  XLEN  dividend.
REQ-009 SHALL have port rs2  input  XLEN  divisor.
REQ-010 SHALL have port rd_in  input  TAGW  destination tag of the issuing instruction.
REQ-011 SHALL have port busy  output  1  unit occupied; drives the decoder hazard input.
REQ-012 SHALL have port done  output  1  one-cycle pulse; result and rd_out valid.
REQ-013 SHALL have port result  output  XLEN  quotient or remainder.
REQ-014 SHALL have port rd_out  output  TAGW  tag captured at start.

Function
REQ-015 start = div_inst && valid divsel && !flush && state==IDLE; sampled on a rising edge.
- div_inst with invalid divsel, div_inst while not IDLE, or div_inst with flush: ignored, no state change.
REQ-016 States: IDLE, CALC, DONE.
- IDLE->CALC on normal start.
- IDLE->DONE on special-case start.
- CALC->DONE after the 32nd iteration.
- DONE->IDLE unconditionally.
- Any state->IDLE on flush; flush overrides all other transitions.
REQ-017 On start, capture:
- operation, rd_in
- sign flags for signed ops
- |rs1| and |rs2| for div/rem; raw values for divu/remu.
REQ-018 CALC: one restoring shift-subtract iteration per cycle; 6-bit iteration counter 0..31; XLEN+1-bit partial remainder.
REQ-019 Sign fix when loading result on the CALC->DONE edge:
- quotient negated iff the operand signs differ (div).
- remainder takes the dividend sign (rem).
REQ-020 Special cases resolved at start with no iterations; DONE is entered on the start edge:
- divisor 0: div/divu -> all-ones; rem/remu -> rs1.
- signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF, div/rem): div -> 0x80000000; rem -> 0.
REQ-021 Latency, counted in edges after the start edge:
- normal op: done high after edge 33.
- special case: done high after edge 1.
REQ-022 Outputs:
- done = (state==DONE); high for exactly one cycle per accepted start.
- result and rd_out hold their value until the next result load.
REQ-023 busy = (state!=IDLE), registered-state decode; busy is low in the cycle after done.
REQ-024 A flush in DONE suppresses nothing already visible; done for that cycle stays high, and the state returns to IDLE.
REQ-025 A flush in CALC drops busy on the next edge; no done is produced for the aborted operation.
REQ-026 A new start is accepted in the first IDLE cycle after DONE or after an abort.

Reset
REQ-027 rst_n low SHALL asynchronously force:
- state=IDLE, counter=0
- busy=0, done=0
- result=0, rd_out=0
- all internal operand registers 0.
REQ-028 Reset mid-CALC SHALL discard the operation; no done after reset release.
REQ-029 Deassertion SHALL take effect at the first rising clk edge after rst_n goes high.

Structure
REQ-030 divsel encodings SHALL live in the shared control package, used by both decoder and div_unit.
REQ-031 The state enum SHALL live in the shared control package.
REQ-032 XLEN default SHALL live in the shared control package.
REQ-033 One combinational sub-module, div_step (single restoring iteration: remainder/quotient in, remainder/quotient out), SHALL be instantiated once.

Verification
REQ-034 divu rs1=100, rs2=7 -> result=14 after edge 33; remu -> 2; busy high for edges 1..33.
REQ-035 div rs1=0xFFFFFFF9 (-7), rs2=2 -> 0xFFFFFFFD; rem -> 0xFFFFFFFF.
REQ-036 div rs1=5, rs2=0 -> 0xFFFFFFFF after edge 1; rem -> 5; divu rs1=0 -> 0xFFFFFFFF.
REQ-037 div rs1=0x80000000, rs2=0xFFFFFFFF -> 0x80000000 after edge 1; rem -> 0.
REQ-038 Flush and start checks:
- flush at edge 10 of a divu -> busy low after edge 11, no done.
- divu 9/3 started in the next IDLE cycle -> 3, with rd_out equal to the new tag.
REQ-039 div_inst held high through a divide -> exactly one done; reset asserted at edge 20 -> all outputs 0 immediately; no done after release.
